bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
//
// PURPOSE
//  Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock).
//  Turns the binary occupancy/free-space count into the packed 4-digit BCD word
//  that the seven-segment digit-mux driver consumes.
//  Holds the result stable between conversions, so the display never shows
//  partial values.
//
// PARAMETERS
//  BIN_W   14  width of binary input (14 covers 0..16383)
//  DIGITS  4   BCD digits produced; digit 0 is least significant
//
// PORTS
//  clk     in   1           single clock; all logic on posedge clk
//  reset   in   1           synchronous, active-high reset
//  start   in   1           request conversion of bin; sampled only in IDLE
//  bin     in   BIN_W       unsigned binary value; captured on accepted start
//  busy    out  1           conversion in progress
//  done    out  1           one-cycle pulse: bcd/ovf/lz updated this cycle
//  bcd     out  4*DIGITS    packed BCD; digit k at bcd[4k+3:4k]
//  ovf     out  1           last captured bin >= 10**DIGITS (bcd saturated)
//  lz      out  DIGITS      leading-zero mask: bit k=1 -> digit k is a blankable leading 0
//
// BEHAVIOUR
//  - Reset values:
//    - state=IDLE; busy=0, done=0, bcd=0, ovf=0.
//    - lz = all ones except bit 0.
//    - Scratch regs and bit counter are cleared.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE:
//    - start=1 at edge N: capture bin into shift reg and clear the BCD scratch.
//    - cnt <= BIN_W; busy <= 1; go to SHIFT.
//  - SHIFT, each edge:
//    - Every scratch digit >= 5 gets +3, in parallel.
//    - Then shift {scratch, bin_sr} left by 1; cnt--.
//    - After the edge that leaves cnt=0 (edge N+BIN_W), go to DONE.
//  - DONE, edge N+BIN_W+1:
//    - Load bcd, ovf and lz; done <= 1 for exactly one cycle.
//    - busy <= 0; go to IDLE.
//    - Latency from the accepting edge to done asserted = BIN_W+1 clocks (15 at defaults).
//  - Overflow: captured value >= 10**DIGITS -> bcd = all 4'h9, ovf=1.
//    - Compare uses the captured value, not the live bin.
//  - lz: bit k set iff digits k..DIGITS-1 are all zero, k >= 1. Bit 0 is always 0.
//  - start while busy (SHIFT or DONE) is ignored; no queueing.
//  - start in the cycle done is high (FSM back in IDLE) is accepted: back-to-back rate is BIN_W+2 clocks.
//  - bin changes during a conversion have no effect.
//  - bcd/ovf/lz change only on the DONE edge or on reset.
//  - Reset mid-conversion: immediate return to reset values.
//    - No done pulse; the partial result is discarded.
//  - All arithmetic is unsigned. Scratch width 4*DIGITS.
//  - The add-3 step is applied only to digits, never to bin_sr.
//
// STRUCTURE
//  - Shared package (display_pkg):
//    - BCD_W=4.
//    - FSM state enum {IDLE,SHIFT,DONE}.
//    - Function pow10(DIGITS) for the overflow limit.
//    - Digit-to-segment constants remain there for the mux driver.
//  - Sub-module bcd_add3: 4-bit combinational "if >=5 add 3".
//    - Instantiated DIGITS times via generate.
//  - Top holds the FSM, counter, shift/scratch regs and output regs.
//
// TESTING
//  1. reset held 3 cycles, then released -> busy=0, done=0, bcd=16'h0000, ovf=0, lz=4'b1110.
//  2. bin=1234, start 1 cycle -> done high exactly 15 clocks later.
//     - bcd=16'h1234, ovf=0, lz=4'b0000; busy high for those 15 clocks.
//  3. bin=0 -> bcd=16'h0000, lz=4'b1110.
//     - Then bin=7 -> bcd=16'h0007, lz=4'b1110.
//     - Then bin=9999 -> bcd=16'h9999, ovf=0.
//  4. bin=12000 -> bcd=16'h9999, ovf=1.
//     - Next conversion, bin=45 -> bcd=16'h0045, ovf=0, lz=4'b1100.
//  5. bin=321 start; start pulse with bin=888 at cycle 5; bin changed to 999 mid-run.
//     - Result: one done, bcd=16'h0321.
//     - Then start in the done cycle with bin=50 -> second done 15 clocks later, bcd=16'h0050.
//  6. bin=1234 done (bcd=16'h1234); then start bin=5678, reset at cycle 8.
//     - No done pulse; bcd=16'h0000, busy=0 the cycle after reset.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared display definitions: BCD digit width, converter FSM states,
// overflow-limit helper and seven-segment patterns for the digit-mux driver.
package display_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 10**n, used as the first value that no longer fits in n BCD digits
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Segment patterns {g,f,e,d,c,b,a}, index = decimal digit
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a count source and the binary-to-BCD converter.
interface bin2bcd_seq_if
  import display_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) ();

  // start is a request, accepted only while the converter is idle (busy=0);
  // there is no backpressure beyond that and nothing is queued. done pulses
  // for exactly one cycle, in which bcd/ovf/lz carry the new result.
  logic                      start;
  logic [BIN_W-1:0]          bin;
  logic                      busy;
  logic                      done;
  logic [BCD_W*DIGITS-1:0]   bcd;
  logic                      ovf;
  logic [DIGITS-1:0]         lz;
  state_t                    state_dbg;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, lz, state_dbg
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, lz, state_dbg
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is >= 5.
module bcd_add3
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: one input bit per clock, result held
// in output registers that only change on the DONE edge or reset.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  localparam int          SCR_W  = BCD_W * DIGITS;
  localparam int          CNT_W  = $clog2(BIN_W + 1);
  localparam int unsigned LIMIT  = pow10(DIGITS);
  localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t             state_q, state_d;
  logic               accept, shift_en, finish;

  logic [BIN_W-1:0]   bin_sr_q;
  logic [SCR_W-1:0]   scr_q;
  logic [SCR_W-1:0]   scr_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;

  logic               busy_q, done_q, ovf_q;
  logic [SCR_W-1:0]   bcd_q;
  logic [DIGITS-1:0]  lz_q;

  logic [SCR_W-1:0]   res_d;
  logic [DIGITS-1:0]  lz_d;
  logic               all_zero;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scr_q[g*BCD_W +: BCD_W]),
      .q (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  // Final digits (saturated on overflow) and the leading-zero mask scanned
  // from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    res_d    = ovf_pend_q ? {DIGITS{4'h9}} : scr_q;
    lz_d     = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (res_d[k*BCD_W +: BCD_W] == BCD_W'(0));
      lz_d[k]  = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr_q   <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      lz_q       <= LZ_RST;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        bin_sr_q   <= bus.bin;
        scr_q      <= '0;
        cnt_q      <= CNT_W'(BIN_W);
        busy_q     <= 1'b1;
        ovf_pend_q <= (32'(bus.bin) >= LIMIT);
      end
      if (shift_en) begin
        {scr_q, bin_sr_q} <= {scr_adj[SCR_W-2:0], bin_sr_q, 1'b0};
        cnt_q             <= cnt_q - CNT_W'(1);
      end
      if (finish) begin
        bcd_q  <= res_d;
        ovf_q  <= ovf_pend_q;
        lz_q   <= lz_d;
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.lz        = lz_q;
  assign bus.state_dbg = state_q;

endmodule
